dual_mem_fifo_ctrl: RTL and testbench

FIFO control stage placed directly upstream of the 1K dual-port RAM (`dual_mem`). It turns a push/pop request interface into the RAM's write/read strobes and addresses, tracks occupancy, and flags when RAM read data is valid. The RAM remains a plain storage array: this block owns the wrap-around pointers, the full/empty protection and the error reporting.

---
 rtl/dual_mem_fifo_ctrl.sv | 116 +++++++++++
 tb/tb_dual_mem_fifo_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dual_mem_fifo_ctrl.sv
// FIFO control stage in front of the dual_mem RAM: wrap-around pointers, occupancy,
// full/empty protection, sticky error flags and read-data-valid tracking.
module dual_mem_fifo_ctrl #(
   parameter int RAM_DEPTH   = 1024,
   parameter int ADDR_SIZE   = 10,
   parameter int AFULL_LEVEL = 1020
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 push,
   input  logic                 pop,
   output logic                 mem_en,
   output logic                 write,
   output logic [ADDR_SIZE-1:0] wr_address,
   output logic                 op_en,
   output logic                 read,
   output logic [ADDR_SIZE-1:0] rd_address,
   output logic                 rd_valid,
   output logic [ADDR_SIZE:0]   count,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 overflow,
   output logic                 underflow
);

   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_DEPTH - 1);
   localparam logic [ADDR_SIZE:0]   DEPTH_CNT = (ADDR_SIZE + 1)'(RAM_DEPTH);
   localparam logic [ADDR_SIZE:0]   AFULL_CNT = (ADDR_SIZE + 1)'(AFULL_LEVEL);

   logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_SIZE:0]   count_q, count_d;
   logic                 op_en_q, op_en_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 overflow_q, overflow_d;
   logic                 underflow_q, underflow_d;
   logic                 push_acc, pop_acc;

   // Depth need not be a power of two, so the wrap is an explicit compare.
   function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + 1'b1;
   endfunction

   assign full        = (count_q == DEPTH_CNT);
   assign empty       = (count_q == '0);
   assign almost_full = (count_q >= AFULL_CNT);

   assign push_acc = push & ~full  & ~clr;
   assign pop_acc  = pop  & ~empty & ~clr;

   assign mem_en     = push_acc;
   assign write      = push_acc;
   assign read       = pop_acc;
   assign wr_address = wr_ptr_q;
   assign rd_address = rd_ptr_q;
   assign count      = count_q;
   assign op_en      = op_en_q;
   assign rd_valid   = rd_valid_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned
      // (which would infer a latch).
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      op_en_d     = 1'b1;
      rd_valid_d  = pop_acc;
      overflow_d  = overflow_q  | (push & full  & ~clr);
      underflow_d = underflow_q | (pop  & empty & ~clr);

      if (push_acc) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_acc)  rd_ptr_d = next_ptr(rd_ptr_q);

      unique case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         rd_valid_d  = 1'b0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         op_en_q     <= 1'b0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         op_en_q     <= op_en_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

endmodule

// File: tb/tb_dual_mem_fifo_ctrl.sv
// Directed bench for dual_mem_fifo_ctrl; a behavioural 1K x 64 RAM sits behind the
// controller so data ordering and wrap-around can be checked end to end.
module tb_dual_mem_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic [63:0] data_in = '0;
   logic        mem_en, write, op_en, read, rd_valid;
   logic [9:0]  wr_address, rd_address;
   logic [10:0] count;
   logic        full, empty, almost_full, overflow, underflow;

   logic [63:0] ram [0:1023];
   logic [63:0] data_out = '0;

   logic       wr_s, en_s, rd_s;
   logic [9:0] wa_s, ra_s;
   int         errors = 0;
   int         checks = 0;

   dual_mem_fifo_ctrl #(.RAM_DEPTH(1024), .ADDR_SIZE(10), .AFULL_LEVEL(1020)) dut (
      .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
      .mem_en(mem_en), .write(write), .wr_address(wr_address), .op_en(op_en),
      .read(read), .rd_address(rd_address), .rd_valid(rd_valid), .count(count),
      .full(full), .empty(empty), .almost_full(almost_full),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Plain storage array standing in for dual_mem.
   always @(posedge clk) begin
      if (mem_en && write) ram[wr_address] <= data_in;
      if (op_en && read)   data_out <= ram[rd_address];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one cycle of requests; strobes are captured mid-cycle, then time
   // advances to just after the edge.
   task automatic step(input logic p, input logic q, input logic c, input logic [63:0] d);
      push = p; pop = q; clr = c; data_in = d;
      @(negedge clk);
      wr_s = write; en_s = mem_en; rd_s = read; wa_s = wr_address; ra_s = rd_address;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0; clr = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      checks++; if (count !== 11'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
      checks++; if ({empty, full, almost_full} !== 3'b100) begin errors++; $display("FAIL rst_flags: got %b want 100", {empty, full, almost_full}); end
      checks++; if ({op_en, rd_valid, overflow, underflow} !== 4'b0000) begin errors++; $display("FAIL rst_regs: got %b want 0000", {op_en, rd_valid, overflow, underflow}); end
      checks++; if ({mem_en, write, read} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b want 000", {mem_en, write, read}); end
      @(posedge clk); #1;
      checks++; if (op_en !== 1'b0) begin errors++; $display("FAIL rst_op_en_held: got %b want 0", op_en); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (op_en !== 1'b1) begin errors++; $display("FAIL rst_op_en_rise: got %b want 1", op_en); end
   endtask

   task automatic test_fill;
      for (int i = 0; i < 1024; i++) begin
         step(1'b1, 1'b0, 1'b0, 64'(i));
         checks++; if (wr_s !== 1'b1 || wa_s !== 10'(i)) begin errors++; $display("FAIL fill_wr[%0d]: write=%b addr=%0d want 1/%0d", i, wr_s, wa_s, i); end
         if (i == 1018) begin
            checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL afull_1019: got %b want 0", almost_full); end
         end
         if (i == 1019) begin
            checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL afull_1020: got %b want 1", almost_full); end
         end
      end
      checks++; if (full !== 1'b1 || empty !== 1'b0 || count !== 11'd1024) begin errors++; $display("FAIL fill_full: full=%b empty=%b count=%0d want 1/0/1024", full, empty, count); end
      checks++; if (wr_address !== 10'd0) begin errors++; $display("FAIL fill_wrap: got %0d want 0", wr_address); end
      // push+pop while full: only the pop goes through
      step(1'b1, 1'b1, 1'b0, 64'hDEAD);
      checks++; if ({wr_s, rd_s} !== 2'b01 || ra_s !== 10'd0) begin errors++; $display("FAIL full_pp_strobes: w/r=%b%b ra=%0d want 01/0", wr_s, rd_s, ra_s); end
      checks++; if (count !== 11'd1023 || overflow !== 1'b1) begin errors++; $display("FAIL full_pp_state: count=%0d ovf=%b want 1023/1", count, overflow); end
      step(1'b1, 1'b0, 1'b0, 64'd1024);
      checks++; if (wa_s !== 10'd0 || count !== 11'd1024) begin errors++; $display("FAIL refill: wa=%0d count=%0d want 0/1024", wa_s, count); end
      step(1'b1, 1'b0, 1'b0, 64'hBAD);
      checks++; if ({wr_s, en_s} !== 2'b00) begin errors++; $display("FAIL ovf_strobe: write/mem_en=%b%b want 00", wr_s, en_s); end
      checks++; if (overflow !== 1'b1 || count !== 11'd1024 || wr_address !== 10'd1) begin errors++; $display("FAIL ovf_state: ovf=%b count=%0d wa=%0d want 1/1024/1", overflow, count, wr_address); end
   endtask

   task automatic test_flush;
      for (int i = 0; i < 724; i++) step(1'b0, 1'b1, 1'b0, '0);
      checks++; if (count !== 11'd300 || rd_address !== 10'd725 || rd_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: count=%0d ra=%0d v=%b want 300/725/1", count, rd_address, rd_valid); end
      step(1'b1, 1'b1, 1'b1, 64'hF00);
      checks++; if ({wr_s, en_s, rd_s} !== 3'b000) begin errors++; $display("FAIL flush_strobes: got %b want 000", {wr_s, en_s, rd_s}); end
      checks++; if (count !== 11'd0 || wr_address !== 10'd0 || rd_address !== 10'd0) begin errors++; $display("FAIL flush_ptrs: count=%0d wa=%0d ra=%0d want 0/0/0", count, wr_address, rd_address); end
      checks++; if ({overflow, empty, rd_valid, op_en} !== 4'b0101) begin errors++; $display("FAIL flush_flags: ovf/empty/valid/op_en=%b want 0101", {overflow, empty, rd_valid, op_en}); end
   endtask

   task automatic test_data_order;
      logic [63:0] words [3];
      words[0] = 64'hA5A5_0000_0000_0001;
      words[1] = 64'hA5A5_0000_0000_0002;
      words[2] = 64'hA5A5_0000_0000_0003;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, words[i]);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, '0);
         checks++; if (rd_s !== 1'b1 || ra_s !== 10'(i)) begin errors++; $display("FAIL order_rd[%0d]: read=%b ra=%0d want 1/%0d", i, rd_s, ra_s, i); end
         checks++; if (rd_valid !== 1'b1 || data_out !== words[i]) begin errors++; $display("FAIL order_data[%0d]: valid=%b data=%h want 1/%h", i, rd_valid, data_out, words[i]); end
      end
      step(1'b0, 1'b1, 1'b0, '0);
      checks++; if (rd_s !== 1'b0) begin errors++; $display("FAIL udf_strobe: read=%b want 0", rd_s); end
      checks++; if ({underflow, rd_valid, empty} !== 3'b101) begin errors++; $display("FAIL udf_state: udf/valid/empty=%b want 101", {underflow, rd_valid, empty}); end
   endtask

   task automatic test_simultaneous;
      step(1'b0, 1'b0, 1'b1, '0);
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clr_udf: got %b want 0", underflow); end
      step(1'b1, 1'b1, 1'b0, 64'h11);
      checks++; if ({wr_s, rd_s} !== 2'b10) begin errors++; $display("FAIL empty_pp_strobes: w/r=%b%b want 10", wr_s, rd_s); end
      checks++; if (count !== 11'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL empty_pp_state: count=%0d udf=%b valid=%b want 1/1/0", count, underflow, rd_valid); end
      for (int i = 0; i < 511; i++) step(1'b1, 1'b0, 1'b0, 64'(i));
      step(1'b1, 1'b1, 1'b0, 64'h22);
      checks++; if ({wr_s, rd_s} !== 2'b11 || wa_s !== 10'd512 || ra_s !== 10'd0) begin errors++; $display("FAIL mid_pp_strobes: w/r=%b%b wa=%0d ra=%0d want 11/512/0", wr_s, rd_s, wa_s, ra_s); end
      checks++; if (count !== 11'd512 || wr_address !== 10'd513 || rd_address !== 10'd1) begin errors++; $display("FAIL mid_pp_state: count=%0d wa=%0d ra=%0d want 512/513/1", count, wr_address, rd_address); end
   endtask

   task automatic test_wrap;
      logic [9:0] exp_addr [4];
      exp_addr[0] = 10'd1022; exp_addr[1] = 10'd1023; exp_addr[2] = 10'd0; exp_addr[3] = 10'd1;
      step(1'b0, 1'b0, 1'b1, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 1021; i++) step(1'b1, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      checks++; if (wr_address !== 10'd1022 || rd_address !== 10'd1022 || count !== 11'd0) begin errors++; $display("FAIL wrap_pre: wa=%0d ra=%0d count=%0d want 1022/1022/0", wr_address, rd_address, count); end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, 64'hC0DE_0000_0000_0000 + 64'(i));
         checks++; if (wa_s !== exp_addr[i]) begin errors++; $display("FAIL wrap_wa[%0d]: got %0d want %0d", i, wa_s, exp_addr[i]); end
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0, '0);
         checks++; if (ra_s !== exp_addr[i]) begin errors++; $display("FAIL wrap_ra[%0d]: got %0d want %0d", i, ra_s, exp_addr[i]); end
         checks++; if (data_out !== 64'hC0DE_0000_0000_0000 + 64'(i)) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, data_out, 64'hC0DE_0000_0000_0000 + 64'(i)); end
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 64'(i));
      step(1'b0, 1'b1, 1'b0, '0);
      checks++; if (count !== 11'd5 || rd_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: count=%0d valid=%b want 5/1", count, rd_valid); end
      rst = 1'b1;
      #1;
      checks++; if (count !== 11'd0 || {empty, rd_valid, op_en} !== 3'b100) begin errors++; $display("FAIL mid_rst: count=%0d empty/valid/op_en=%b want 0/100", count, {empty, rd_valid, op_en}); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (op_en !== 1'b1 || count !== 11'd0) begin errors++; $display("FAIL mid_release: op_en=%b count=%0d want 1/0", op_en, count); end
   endtask

   initial begin
      test_reset;
      test_fill;
      test_flush;
      test_data_order;
      test_simultaneous;
      test_wrap;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
